// File: rtl/aes_inv_key_sched.sv
// aes_inv_key_sched: AES key expansion presenting round keys Nr..0, re-deriving earlier words backwards.
// Define INV_KEY_SCHED_MIXCOL_EN to output InvMixColumns of rounds 1..Nr-1 (equivalent inverse cipher).
module aes_inv_key_sched #(
   parameter int Nk = 4,
   parameter int Nr = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [0:32*Nk-1]  key_in,
   output logic              busy,
   output logic              rk_valid,
   input  logic              rk_ready,
   output logic [0:127]      rk_data,
   output logic [3:0]        rk_round,
   output logic              rk_last
);
   typedef enum logic [1:0] {IDLE, FWD, EMIT, BACK} stateT;
   localparam logic [5:0] FINAL = 6'(4*(Nr+1)-Nk);
   localparam logic [0:2047] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
   localparam logic [0:127] RCON = 128'h0001020408102040801b360000000000;
   stateT state;
   logic [0:32*Nk-1] win;
   logic [5:0] j;
   logic [3:0] r;
   logic [31:0] fwdWord, backWord;
   logic [0:255] winPad;
   logic [2:0] off;
   logic [0:127] rawKey;

   function automatic logic [7:0] sb(input logic [7:0] b);
      return SBOX[{b, 3'b000} +: 8];
   endfunction

   function automatic logic [31:0] subWord(input logic [31:0] w);
      return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
   endfunction

   function automatic logic [31:0] f(input logic [31:0] w, input logic [5:0] i);
      logic [5:0] m, q;
      m = i % 6'(Nk);
      q = i / 6'(Nk);
      return (m == 6'd0) ? subWord({w[23:0], w[31:24]}) ^ {RCON[{q[3:0], 3'b000} +: 8], 24'h0}
           : (Nk > 6 && m == 6'd4) ? subWord(w) : w;
   endfunction

   // window word 0 is w[j]; the round key starts at window offset 4r-j
   always_comb begin
      fwdWord = win[0:31] ^ f(win[32*Nk-32 +: 32], j + 6'(Nk));
      backWord = win[32*Nk-32 +: 32] ^ f(win[32*Nk-64 +: 32], j - 6'd1 + 6'(Nk));
      off = 3'({r, 2'b00} - j);
      winPad = '0;
      winPad[0:32*Nk-1] = win;
      rawKey = 128'(winPad >> (8'd128 - {off, 5'b00000}));
   end

`ifdef INV_KEY_SCHED_MIXCOL_EN
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] invCol(input logic [31:0] c);
      logic [7:0] a, x2, x4, x8;
      logic [7:0] m9 [4], mb [4], md [4], me [4];
      for (int k = 0; k < 4; k++) begin
         a = c[31-8*k -: 8];
         x2 = xt(a);
         x4 = xt(x2);
         x8 = xt(x4);
         m9[k] = x8 ^ a;
         mb[k] = x8 ^ x2 ^ a;
         md[k] = x8 ^ x4 ^ a;
         me[k] = x8 ^ x4 ^ x2;
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3], m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3], mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   assign rk_data = !rk_valid ? '0
                  : (r == 4'd0 || r == 4'(Nr)) ? rawKey
                  : {invCol(rawKey[0:31]), invCol(rawKey[32:63]), invCol(rawKey[64:95]), invCol(rawKey[96:127])};
`else
   assign rk_data = rk_valid ? rawKey : '0;
`endif
   assign rk_round = r;
   assign rk_last = rk_valid && r == 4'd0;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         win <= '0;
         j <= '0;
         r <= '0;
         busy <= 1'b0;
         rk_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               win <= key_in;
               j <= '0;
               r <= 4'(Nr);
               busy <= 1'b1;
               state <= FWD;
            end
            FWD: if (j == FINAL) begin
               rk_valid <= 1'b1;
               state <= EMIT;
            end else begin
               win <= {win[32:32*Nk-1], fwdWord};
               j <= j + 6'd1;
            end
            EMIT: if (rk_ready) begin
               if (r == 4'd0) begin
                  busy <= 1'b0;
                  rk_valid <= 1'b0;
                  state <= IDLE;
               end else begin
                  r <= r - 4'd1;
                  if ({r - 4'd1, 2'b00} < j) begin
                     rk_valid <= 1'b0;
                     state <= BACK;
                  end
               end
            end
            BACK: begin
               win <= {backWord, win[0:32*Nk-33]};
               j <= j - 6'd1;
               if (j - 6'd1 == {r, 2'b00}) begin
                  rk_valid <= 1'b1;
                  state <= EMIT;
               end
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_aes_inv_key_sched.sv
// tb_aes_inv_key_sched: random and known-answer checks of Nk=4/6/8 instances against a
// forward-only FIPS-197 expansion model with a GF(2^8)-derived S-box.
module tb_aes_inv_key_sched;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic [2:0] start, rkReady, busy, rkValid, rkLast;
   logic [0:127] rkData [3];
   logic [3:0] rkRound [3];
   logic [0:255] key [3];

   aes_inv_key_sched #(.Nk(4), .Nr(10)) u4 (.clk(clk), .rst_n(rst_n), .start(start[0]), .key_in(key[0][0:127]),
      .busy(busy[0]), .rk_valid(rkValid[0]), .rk_ready(rkReady[0]), .rk_data(rkData[0]),
      .rk_round(rkRound[0]), .rk_last(rkLast[0]));
   aes_inv_key_sched #(.Nk(6), .Nr(12)) u6 (.clk(clk), .rst_n(rst_n), .start(start[1]), .key_in(key[1][0:191]),
      .busy(busy[1]), .rk_valid(rkValid[1]), .rk_ready(rkReady[1]), .rk_data(rkData[1]),
      .rk_round(rkRound[1]), .rk_last(rkLast[1]));
   aes_inv_key_sched #(.Nk(8), .Nr(14)) u8 (.clk(clk), .rst_n(rst_n), .start(start[2]), .key_in(key[2]),
      .busy(busy[2]), .rk_valid(rkValid[2]), .rk_ready(rkReady[2]), .rk_data(rkData[2]),
      .rk_round(rkRound[2]), .rk_last(rkLast[2]));

   int checks = 0;
   int errors = 0;
   logic [7:0] sboxT [256];
   logic [7:0] rconT [11];
   logic [31:0] ws [60];
   logic [0:127] cap [15];

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] t);
      return {sboxT[t[31:24]], sboxT[t[23:16]], sboxT[t[15:8]], sboxT[t[7:0]]};
   endfunction

   function automatic logic [0:127] invMixTb(input logic [0:127] x);
      logic [7:0] coef [4];
      logic [7:0] acc;
      logic [0:127] y;
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
      for (int c = 0; c < 4; c++)
         for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) acc ^= gmul(coef[(k - row + 4) % 4], x[32*c+8*k +: 8]);
            y[32*c+8*row +: 8] = acc;
         end
      return y;
   endfunction

   task automatic expand(input int nk, input logic [0:255] k);
      logic [31:0] t;
      for (int i = 0; i < 4 * (nk + 7); i++) begin
         if (i < nk) ws[i] = k[32*i +: 32];
         else begin
            t = ws[i-1];
            if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rconT[i/nk], 24'h0};
            else if (nk > 6 && i % nk == 4) t = subw(t);
            ws[i] = ws[i-nk] ^ t;
         end
      end
   endtask

   function automatic logic [0:127] expKey(input int nr, input int r);
      logic [0:127] raw;
      raw = {ws[4*r], ws[4*r+1], ws[4*r+2], ws[4*r+3]};
`ifdef INV_KEY_SCHED_MIXCOL_EN
      if (r > 0 && r < nr) raw = invMixTb(raw);
`endif
      return raw;
   endfunction

   task automatic waitValid(input int d, output int cyc);
      cyc = 0;
      while (!rkValid[d] && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic runSched(input int d, input logic [0:255] k, input int stallPct);
      int nk, nr, cyc;
      logic [0:127] e;
      nk = 4 + 2 * d;
      nr = nk + 6;
      expand(nk, k);
      key[d] = k;
      rkReady[d] = 1'b0;
      start[d] = 1'b1;
      @(posedge clk); #1;
      start[d] = 1'b0;
      check("busyStart", busy[d], 1);
      for (int r = nr; r >= 0; r--) begin
         waitValid(d, cyc);
         if (r == nr) check("latency", cyc, 4 * (nr + 1) - nk + 1);
         else if (nk == 4) check("backCycles", cyc, 4);
         check("valid", rkValid[d], 1);
         e = expKey(nr, r);
         check("data", rkData[d], e);
         check("round", rkRound[d], r);
         check("last", rkLast[d], r == 0);
         cap[r] = rkData[d];
         for (int s = 0; s < 16; s++) begin
            rkReady[d] = (s == 15) || ($urandom_range(99) >= stallPct);
            @(posedge clk); #1;
            if (rkReady[d]) break;
            check("holdData", rkData[d], e);
            check("holdRound", rkRound[d], r);
         end
         rkReady[d] = 1'b0;
      end
      check("busyEnd", busy[d], 0);
      check("validEnd", rkValid[d], 0);
   endtask

   task automatic checkZero(input string tag);
      check({tag, "Busy"}, busy[0], 0);
      check({tag, "Valid"}, rkValid[0], 0);
      check({tag, "Data"}, rkData[0], 0);
      check({tag, "Round"}, rkRound[0], 0);
      check({tag, "Last"}, rkLast[0], 0);
   endtask

   function automatic logic [0:255] randKey();
      logic [0:255] k;
      for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
      return k;
   endfunction

   initial begin
      logic [7:0] inv, base, rc;
      logic [0:255] k;
      int e, cyc, sawValid;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h01;
         base = 8'(x);
         e = 254;
         while (e != 0) begin
            if (e % 2 == 1) inv = gmul(inv, base);
            base = gmul(base, base);
            e = e / 2;
         end
         if (x == 0) inv = 8'h00;
         sboxT[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      end
      rc = 8'h01;
      rconT[0] = 8'h00;
      for (int i = 1; i <= 10; i++) begin
         rconT[i] = rc;
         rc = gmul(rc, 8'h02);
      end
      start = '0;
      rkReady = '0;
      for (int d = 0; d < 3; d++) key[d] = '0;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkZero("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      runSched(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 0);
      check("kat128r10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`ifdef INV_KEY_SCHED_MIXCOL_EN
      check("kat128r1mix", cap[1], invMixTb(128'ha0fafe1788542cb123a339392a6c7605));
`else
      check("kat128r1", cap[1], 128'ha0fafe1788542cb123a339392a6c7605);
`endif
      check("kat128r0", cap[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
      runSched(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 0);
      check("katSeqR10", cap[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
      runSched(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 0);
      check("kat256r14", cap[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);
      check("kat256r0", cap[0], 128'h000102030405060708090a0b0c0d0e0f);
      runSched(1, randKey(), 50);
      for (int n = 0; n < 4; n++) runSched($urandom_range(2), randKey(), 30);

      k = randKey();
      expand(4, k);
      key[0] = k;
      start[0] = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0;
      waitValid(0, cyc);
      check("ignValid", rkValid[0], 1);
      rkReady[0] = 1'b1;
      @(posedge clk); #1;
      rkReady[0] = 1'b0;
      check("inBack", rkValid[0], 0);
      key[0] = ~k;
      start[0] = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0;
      waitValid(0, cyc);
      check("ignData", rkData[0], expKey(10, 9));
      check("ignRound", rkRound[0], 9);
      rkReady[0] = 1'b1;
      cyc = 0;
      while (busy[0] && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      rkReady[0] = 1'b0;
      check("drainIdle", busy[0], 0);
      start[0] = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("fwdBusy", busy[0], 1);
      rst_n = 1'b0;
      #1;
      checkZero("async");
      @(posedge clk); #1;
      rst_n = 1'b1;
      rkReady[0] = 1'b1;
      sawValid = 0;
      repeat (60) begin
         @(posedge clk); #1;
         if (rkValid[0]) sawValid++;
      end
      rkReady[0] = 1'b0;
      check("noPartial", sawValid, 0);
      runSched(0, randKey(), 20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
